// File: rtl/pixel_pair_serializer_if.sv
// Bundle of the pixel-pair input bus and the single-pixel output stream
// of pixel_pair_serializer. The slave modport is the serializer's view;
// the master modport is the view of whatever drives pairs in and sinks
// pixels out.
interface pixel_pair_serializer_if;
    logic       in_Frame_Start;
    logic       in_Valid;
    logic [7:0] in_R_Even;
    logic [7:0] in_G_Even;
    logic [7:0] in_B_Even;
    logic [7:0] in_R_Odd;
    logic [7:0] in_G_Odd;
    logic [7:0] in_B_Odd;
    logic       out_Ready;
    logic       out_Valid;
    logic [7:0] out_R;
    logic [7:0] out_G;
    logic [7:0] out_B;
    logic       out_Last_In_Row;
    logic       out_Last_In_Frame;
    logic       overflow_Flag;
    logic       done_Flag;

    modport slave (
        input  in_Frame_Start, in_Valid,
        input  in_R_Even, in_G_Even, in_B_Even,
        input  in_R_Odd, in_G_Odd, in_B_Odd,
        input  out_Ready,
        output out_Valid, out_R, out_G, out_B,
        output out_Last_In_Row, out_Last_In_Frame,
        output overflow_Flag, done_Flag
    );

    modport master (
        output in_Frame_Start, in_Valid,
        output in_R_Even, in_G_Even, in_B_Even,
        output in_R_Odd, in_G_Odd, in_B_Odd,
        output out_Ready,
        input  out_Valid, out_R, out_G, out_B,
        input  out_Last_In_Row, out_Last_In_Frame,
        input  overflow_Flag, done_Flag
    );
endinterface

// File: rtl/pixel_pair_serializer.sv
// pixel_pair_serializer: buffers even/odd RGB pixel pairs from the image
// reader in a small FIFO and emits them one pixel per handshake, tagging
// each pixel with row-end / frame-end flags. Upstream cannot be stalled,
// so a pair arriving at a full FIFO is dropped and a sticky overflow flag
// is raised.
// Optional build macro PIXEL_PAIR_GRAYSCALE_EN: when defined, every output
// channel carries (R + 2G + B) >> 2 of the selected pixel.
module pixel_pair_serializer #(
    parameter int IMAGE_WIDTH     = 768,
    parameter int IMAGE_HEIGHT    = 512,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    pixel_pair_serializer_if.slave  bus
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] S_EVEN = 1'b0;
    localparam logic [0:0] S_ODD  = 1'b1;

    // Entry layout: {odd R, odd G, odd B, even R, even G, even B}
    logic [47:0]                mem_array [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]           count_reg;
    logic [0:0]                 state_reg;
    logic [COL_W-1:0]           col_reg;
    logic [ROW_W-1:0]           row_reg;
    logic                       overflow_reg;
    logic                       done_reg;

    logic        fifo_empty;
    logic        fifo_full;
    logic        handshake;
    logic        pop;
    logic        push;
    logic        drop;
    logic        last_in_row;
    logic        last_in_frame;
    logic [47:0] head_data;
    logic [47:0] push_data;
    logic [7:0]  sel_ch [3];

    assign fifo_empty    = (count_reg == '0);
    assign fifo_full     = (count_reg == CNT_FULL);
    assign handshake     = !fifo_empty && bus.out_Ready;
    assign pop           = handshake && (state_reg == S_ODD);
    assign push          = bus.in_Valid && (!fifo_full || pop);
    assign drop          = bus.in_Valid && fifo_full && !pop;
    assign last_in_row   = (col_reg == COL_LAST);
    assign last_in_frame = last_in_row && (row_reg == ROW_LAST);

    assign push_data = {bus.in_R_Odd,  bus.in_G_Odd,  bus.in_B_Odd,
                        bus.in_R_Even, bus.in_G_Even, bus.in_B_Even};

    // The head entry is read combinationally so a pair written at one edge
    // is presented in the very next cycle.
    assign head_data = mem_array[rd_ptr_reg];

    // Channel select: index 2 = R, 1 = G, 0 = B; odd half in the upper 24 bits
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch_sel
            assign sel_ch[gi] = (state_reg == S_ODD) ? head_data[24 + 8*gi +: 8]
                                                     : head_data[8*gi +: 8];
        end
    endgenerate

`ifdef PIXEL_PAIR_GRAYSCALE_EN
    logic [9:0] gray_sum;
    assign gray_sum  = {2'b00, sel_ch[2]} + {1'b0, sel_ch[1], 1'b0} + {2'b00, sel_ch[0]};
    assign bus.out_R = gray_sum[9:2];
    assign bus.out_G = gray_sum[9:2];
    assign bus.out_B = gray_sum[9:2];
`else
    assign bus.out_R = sel_ch[2];
    assign bus.out_G = sel_ch[1];
    assign bus.out_B = sel_ch[0];
`endif

    assign bus.out_Valid         = !fifo_empty;
    assign bus.out_Last_In_Row   = last_in_row;
    assign bus.out_Last_In_Frame = last_in_frame;
    assign bus.overflow_Flag     = overflow_reg;
    assign bus.done_Flag         = done_reg;

    // FIFO storage write; the array holds no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (!reset && !bus.in_Frame_Start && push) begin
            mem_array[wr_ptr_reg] <= push_data;
        end
    end

    // FIFO pointers/occupancy, serializer FSM, position counters and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= S_EVEN;
            col_reg      <= '0;
            row_reg      <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else if (bus.in_Frame_Start) begin
            // Resync: flush everything except the sticky overflow record
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= S_EVEN;
            col_reg    <= '0;
            row_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (handshake) begin
                state_reg <= (state_reg == S_EVEN) ? S_ODD : S_EVEN;
                if (last_in_row) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end

            if (drop) begin
                overflow_reg <= 1'b1;
            end
            done_reg <= handshake && last_in_frame;
        end
    end

endmodule

// File: tb/tb_pixel_pair_serializer.sv
// Testbench for pixel_pair_serializer with a small geometry (4x2 image,
// 4-entry FIFO). A reference model holds the expected pixel stream in a
// queue: pixels (with their expected row/frame flags) are pushed when a
// pair is driven and accepted, and popped/compared when the sink handshakes.
module tb_pixel_pair_serializer;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [23:0] px;
        logic        lr;
        logic        lf;
    } exp_pix_t;

    logic clk = 1'b0;
    logic reset;

    pixel_pair_serializer_if bus ();

    pixel_pair_serializer #(
        .IMAGE_WIDTH     (W),
        .IMAGE_HEIGHT    (H),
        .FIFO_DEPTH      (DEPTH),
        .FIFO_ADDR_WIDTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_pix_t exp_q [$];
    int  check_count = 0;
    int  fail_count  = 0;
    int  pcol = 0;
    int  prow = 0;
    int  dut_hs_count = 0;
    logic exp_ovf  = 1'b0;
    logic exp_done = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [23:0] exp_color(input logic [23:0] rgb);
`ifdef PIXEL_PAIR_GRAYSCALE_EN
        logic [9:0] s;
        s = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
        return {s[9:2], s[9:2], s[9:2]};
`else
        return rgb;
`endif
    endfunction

    task automatic model_push_pixel(input logic [23:0] rgb);
        exp_pix_t e;
        e.px = exp_color(rgb);
        e.lr = (pcol == W - 1);
        e.lf = e.lr && (prow == H - 1);
        exp_q.push_back(e);
        if (pcol == W - 1) begin
            pcol = 0;
            prow = (prow == H - 1) ? 0 : prow + 1;
        end else begin
            pcol++;
        end
    endtask

    task automatic drive(input logic valid, input logic [23:0] even_px,
                         input logic [23:0] odd_px);
        bus.in_Valid  = valid;
        bus.in_R_Even = even_px[23:16];
        bus.in_G_Even = even_px[15:8];
        bus.in_B_Even = even_px[7:0];
        bus.in_R_Odd  = odd_px[23:16];
        bus.in_G_Odd  = odd_px[15:8];
        bus.in_B_Odd  = odd_px[7:0];
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model
    task automatic step();
        exp_pix_t e;
        logic exp_valid;
        logic hs;
        logic pop;
        logic nd;
        int   pairs;
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        check_value("out_valid", {31'b0, bus.out_Valid}, {31'b0, exp_valid});
        check_value("overflow", {31'b0, bus.overflow_Flag}, {31'b0, exp_ovf});
        check_value("done", {31'b0, bus.done_Flag}, {31'b0, exp_done});
        if (exp_valid) begin
            check_value("pixel", {8'b0, bus.out_R, bus.out_G, bus.out_B}, {8'b0, exp_q[0].px});
            check_value("last_row", {31'b0, bus.out_Last_In_Row}, {31'b0, exp_q[0].lr});
            check_value("last_frame", {31'b0, bus.out_Last_In_Frame}, {31'b0, exp_q[0].lf});
        end
        if (bus.out_Valid && bus.out_Ready) dut_hs_count++;
        hs = exp_valid && bus.out_Ready;
        nd = 1'b0;
        if (bus.in_Frame_Start) begin
            exp_q.delete();
            pcol = 0;
            prow = 0;
        end else begin
            pop   = hs && (exp_q.size() % 2 == 1);
            pairs = (exp_q.size() + 1) / 2;
            if (hs) begin
                e  = exp_q.pop_front();
                nd = e.lf;
                $display("pixel rgb=%06h last_row=%0b last_frame=%0b", e.px, e.lr, e.lf);
            end
            if (bus.in_Valid) begin
                if (pairs < DEPTH || pop) begin
                    model_push_pixel({bus.in_R_Even, bus.in_G_Even, bus.in_B_Even});
                    model_push_pixel({bus.in_R_Odd, bus.in_G_Odd, bus.in_B_Odd});
                end else begin
                    exp_ovf = 1'b1;
                    $display("pair dropped (fifo full)");
                end
            end
        end
        exp_done = nd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_Frame_Start = 1'b0;
        bus.out_Ready = 1'b0;
        drive(1'b0, 24'h0, 24'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        pcol = 0;
        prow = 0;
        exp_ovf = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic push_pairs(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, {base + 8'(6*i), base + 8'(6*i+1), base + 8'(6*i+2)},
                        {base + 8'(6*i+3), base + 8'(6*i+4), base + 8'(6*i+5)});
            step();
        end
        drive(1'b0, 24'h0, 24'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Single pair, sink always ready
        do_reset();
        step();
        bus.out_Ready = 1'b1;
        drive(1'b1, {8'd10, 8'd20, 8'd30}, {8'd40, 8'd50, 8'd60});
        step();
        drive(1'b0, 24'h0, 24'h0);
        idle(4);
        push_pairs(1, 8'h70);   // lands at columns 2 and 3
        idle(3);

        // Sink stalls for five cycles with one pair queued
        do_reset();
        push_pairs(1, 8'h11);
        idle(5);
        bus.out_Ready = 1'b1;
        idle(3);

        // Full 4x2 frame: row/frame flags and done pulse, then wrap
        do_reset();
        bus.out_Ready = 1'b1;
        push_pairs(4, 8'h20);
        idle(8);
        push_pairs(1, 8'hA0);
        idle(3);

        // Overflow: six pairs into four entries, then drain
        do_reset();
        push_pairs(6, 8'h40);
        dut_hs_count = 0;
        bus.out_Ready = 1'b1;
        idle(10);
        check_value("drain_count", dut_hs_count, 8);

        // Full FIFO, push coinciding with the odd handshake
        do_reset();
        push_pairs(4, 8'h80);
        bus.out_Ready = 1'b1;
        step();
        push_pairs(1, 8'hC0);
        idle(12);

        // Frame resync mid-row with three pairs buffered
        do_reset();
        push_pairs(3, 8'h90);
        bus.out_Ready = 1'b1;
        step();
        bus.out_Ready = 1'b0;
        bus.in_Frame_Start = 1'b1;
        drive(1'b1, 24'hDEAD01, 24'hBEEF02);
        step();
        bus.in_Frame_Start = 1'b0;
        drive(1'b0, 24'h0, 24'h0);
        step();
        bus.out_Ready = 1'b1;
        push_pairs(2, 8'hE0);
        idle(6);

        // Randomised traffic with occasional resync
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.out_Ready = ($urandom_range(0, 1) == 1);
            bus.in_Frame_Start = ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 2) != 0), 24'($urandom), 24'($urandom));
            step();
        end
        bus.in_Frame_Start = 1'b0;
        drive(1'b0, 24'h0, 24'h0);
        bus.out_Ready = 1'b1;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/pixel_pair_serializer.md
Name: pixel_pair_serializer

Overview:
- Stage directly downstream of the image reader, which emits one even and one odd 24-bit RGB pixel per cycle while its horizontal pulse is high.
- Buffers incoming pixel pairs in a small FIFO and serializes them into a single-pixel stream with a valid/ready handshake.
- Tracks row and column of every emitted pixel and flags row end, frame end and frame completion for the writer/sink stage.
- Upstream has no backpressure, so FIFO overflow is detected and reported, never stalled.

Parameters:
- IMAGE_WIDTH, 768, pixels per row (even, ≥2)
- IMAGE_HEIGHT, 512, rows per frame (≥1)
- FIFO_DEPTH, 16, pair entries in FIFO (power of 2, ≥2)
- FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_Frame_Start  input  1  level, from upstream vertical pulse; high = resync
- in_Valid  input  1  pair valid this cycle (upstream horizontal pulse)
- in_R_Even, in_G_Even, in_B_Even  input  8 each  even pixel
- in_R_Odd, in_G_Odd, in_B_Odd  input  8 each  odd pixel
- out_Ready  input  1  sink accepts pixel
- out_Valid  output  1  out_R/G/B hold a valid pixel
- out_R, out_G, out_B  output  8 each  serialized pixel
- out_Last_In_Row  output  1  current pixel is column IMAGE_WIDTH-1
- out_Last_In_Frame  output  1  current pixel is last column of row IMAGE_HEIGHT-1
- overflow_Flag  output  1  sticky: a pair was dropped
- done_Flag  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (reset=1 at edge): FIFO empty, FSM in S_EVEN, column=0, row=0, overflow_Flag=0, done_Flag=0. Outputs: out_Valid=0 (FIFO empty); out_R/G/B present FIFO head read contents and are don't-care while out_Valid=0.
- FIFO: 48-bit entries {odd RGB, even RGB}, registered write, head readable combinationally.
- Push when in_Valid && (!full || pop this cycle).
- pop = odd pixel handshake (state S_ODD && out_Valid && out_Ready).
- Full and no pop: pair dropped, overflow_Flag set; it stays set until reset (in_Frame_Start does not clear it).
- Latency: a pair written at edge N makes its even pixel visible with out_Valid=1 in the cycle after edge N.
- FSM with two states, both gated by out_Valid = !empty:
  - S_EVEN: output is head even pixel; on handshake go to S_ODD.
  - S_ODD: output is head odd pixel; on handshake pop and go to S_EVEN.
- No handshake: state and outputs hold. out_Valid never drops while a pixel is presented and not accepted.
- Position counters advance only on a handshake:
  - column increments; at IMAGE_WIDTH-1 it wraps to 0 and row increments.
  - at row IMAGE_HEIGHT-1 and column IMAGE_WIDTH-1, row wraps to 0.
- out_Last_In_Row = (column==IMAGE_WIDTH-1).
- out_Last_In_Frame = out_Last_In_Row && (row==IMAGE_HEIGHT-1).
- Both flags are combinational on the counters and qualified by out_Valid at the sink.
- done_Flag: registered, high exactly one cycle after the handshake of the out_Last_In_Frame pixel.
- in_Frame_Start=1 (any cycle):
  - next edge empties the FIFO, forces S_EVEN, and clears column and row.
  - a concurrent in_Valid pair is discarded.
  - done_Flag is not asserted.
  - takes priority over push and pop.
- Counter widths are $clog2 of their bounds; no arithmetic overflow is possible.

Optional Feature:
- Macro: PIXEL_PAIR_GRAYSCALE_EN
- Defined: each serialized output channel equals (R + 2·G + B) >> 2, computed with a 10-bit intermediate from the selected pixel; out_R = out_G = out_B. Combinational, so latency is unchanged.
- Undefined: out_R/G/B pass the selected pixel's channels unmodified.

Test Plan:
- Reset, then one pair even=(10,20,30), odd=(40,50,60) with out_Ready=1 → out_Valid for 2 consecutive cycles: (10,20,30) then (40,50,60); out_Valid=0 afterwards; column=2.
- out_Ready=0 for 5 cycles with one pair queued → out_Valid held at 1 and even pixel stable; release → even then odd pixel follow.
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, 4 pairs, out_Ready=1 → out_Last_In_Row on pixels 3 and 7; out_Last_In_Frame on pixel 7 only; done_Flag one cycle after pixel 7; counters back to 0.
- FIFO_DEPTH=4, out_Ready=0, 6 consecutive in_Valid pairs → first 4 stored, overflow_Flag=1 from the 5th; drain yields exactly 8 pixels in order.
- Full FIFO, out_Ready=1, push coinciding with odd handshake → pair accepted, overflow_Flag stays 0.
- in_Frame_Start=1 mid-row with 3 pairs buffered → next cycle out_Valid=0, column=0, row=0; following pair emitted as column 0.
